sram_march_bist: RTL and testbench



---
 rtl/sram_march_bist_pkg.sv | 53 +++++
 rtl/sram_march_bist_if.sv | 18 +
 rtl/sram_march_bist_addr_gen.sv | 41 ++++
 rtl/sram_march_bist.sv | 175 +++++++++++++++++
 tb/tb_sram_march_bist.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sram_march_bist_pkg.sv
// March C- BIST shared types: FSM states, element encoding and per-element op table.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_e;

  // One row of the March C- table. d0 is the data of the first op (expected
  // value when the first op is a read), d1 the data written by the second op.
  typedef struct packed {
    logic down;
    logic two_op;
    logic first_rd;
    logic d0;
    logic d1;
  } elem_cfg_t;

  // Sweep direction alone, so callers that only need it do not carry the whole row.
  function automatic logic elem_down(march_elem_e e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic elem_cfg_t elem_cfg(march_elem_e e);
    elem_cfg_t c;
    c = '0;
    c.down = elem_down(e);
    case (e)
      E0: begin c.two_op = 1'b0; c.first_rd = 1'b0; c.d0 = 1'b0; c.d1 = 1'b0; end
      E1: begin c.two_op = 1'b1; c.first_rd = 1'b1; c.d0 = 1'b0; c.d1 = 1'b1; end
      E2: begin c.two_op = 1'b1; c.first_rd = 1'b1; c.d0 = 1'b1; c.d1 = 1'b0; end
      E3: begin c.two_op = 1'b1; c.first_rd = 1'b1; c.d0 = 1'b0; c.d1 = 1'b1; end
      E4: begin c.two_op = 1'b1; c.first_rd = 1'b1; c.d0 = 1'b1; c.d1 = 1'b0; end
      E5: begin c.two_op = 1'b0; c.first_rd = 1'b1; c.d0 = 1'b0; c.d1 = 1'b0; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Functional SRAM request port driven by the BIST (master) towards the macro mux (slave).
// Latency: read data returns one cycle after a read request.
// Backpressure: none; the macro accepts one request every cycle.
interface sram_march_bist_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64,
  parameter int BeWidth   = 8
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [BeWidth-1:0]   be;
  logic [DataWidth-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input rdata);
  modport slave  (input req, we, addr, wdata, be, output rdata);
endinterface

// File: rtl/sram_march_bist_addr_gen.sv
// Up/down address counter over 0..NumWords-1 with explicit wrap at both ends.
// Latency: new address visible the cycle after step_i/clr_i.
// Backpressure: holds its value whenever step_i is low.
module sram_bist_addr_gen #(
  parameter int NumWords  = 256,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic                 down_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  localparam logic [AddrWidth-1:0] MaxAddr = AddrWidth'(NumWords - 1);

  logic [AddrWidth-1:0] addr_q, addr_d;

  // Next address: wrap compares against N-1 so non-power-of-two depths never overrun.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (step_i) begin
      if (down_i) addr_d = (addr_q == '0) ? MaxAddr : addr_q - AddrWidth'(1);
      else        addr_d = (addr_q == MaxAddr) ? '0 : addr_q + AddrWidth'(1);
    end
  end

  // Address register.
  always_ff @(posedge clk_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == MaxAddr);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for one latency-1 single-port SRAM; reports first failing address/element.
// Latency: 10*N request cycles, one drain cycle, done in cycle 10N+2; mismatch -> done two cycles after the read.
// Backpressure: none; one request per RUN cycle, start_i only honoured in IDLE/DONE.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int NumWords  = 256,
  parameter int DataWidth = 64,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int AddrWidth = $clog2(NumWords),
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  sram_march_bist_if.master    mem
);

  if (Latency != 1) begin : g_lat_chk
    $fatal(1, "sram_march_bist: only macro read latency 1 is supported");
  end
  if (NumWords < 2) begin : g_depth_chk
    $fatal(1, "sram_march_bist: NumWords must be at least 2");
  end

  state_e               state_q, state_d;
  march_elem_e          elem_q, elem_d;
  logic                 op_q, op_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 exp_q, exp_d;
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  march_elem_e          rd_elem_q, rd_elem_d;
  logic                 pass_q, pass_d;
  logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
  march_elem_e          fail_elem_q, fail_elem_d;

  elem_cfg_t            cfg;
  logic                 nx_down;
  logic                 run, cur_rd, cur_dat, op_last, sweep_end;
  logic                 cmp_en, mismatch;
  logic                 addr_clr, addr_step, addr_last;
  logic [AddrWidth-1:0] addr;

  sram_bist_addr_gen #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (addr_clr),
    .step_i (addr_step),
    .down_i (cfg.down),
    .addr_o (addr),
    .last_o (addr_last)
  );

  // Decode the current op from registered element/op state and compare last cycle's read.
  always_comb begin
    cfg       = elem_cfg(elem_q);
    nx_down   = elem_down(march_elem_e'(elem_q + 3'd1));
    run       = (state_q == S_RUN);
    cur_rd    = ~op_q & cfg.first_rd;
    cur_dat   = op_q ? cfg.d1 : cfg.d0;
    op_last   = ~cfg.two_op | op_q;
    sweep_end = op_last & addr_last;
    cmp_en    = rd_vld_q & ((state_q == S_RUN) | (state_q == S_DRAIN));
    mismatch  = cmp_en & (mem.rdata != {DataWidth{exp_q}});
  end

  // Next-state logic: sequencing through the elements and first-fail capture.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    rd_vld_d    = rd_vld_q;
    exp_d       = exp_q;
    rd_addr_d   = rd_addr_q;
    rd_elem_d   = rd_elem_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    addr_clr    = 1'b0;
    addr_step   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_RUN;
          elem_d      = E0;
          op_d        = 1'b0;
          rd_vld_d    = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = E0;
          addr_clr    = 1'b1;
        end
      end
      S_RUN: begin
        rd_vld_d  = cur_rd;
        exp_d     = cur_dat;
        rd_addr_d = addr;
        rd_elem_d = elem_q;
        op_d      = ~op_last;
        // At a sweep end the counter wraps into the next element only when the
        // direction is kept; on a reversal it already sits on the new start address.
        addr_step = op_last & (~addr_last | (nx_down == cfg.down));
        if (sweep_end && elem_q != E5) elem_d = march_elem_e'(elem_q + 3'd1);
        if (mismatch) begin
          state_d     = S_DONE;
          pass_d      = 1'b0;
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end else if (sweep_end && elem_q == E5) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_vld_d = 1'b0;
        state_d  = S_DONE;
        pass_d   = ~mismatch;
        if (mismatch) begin
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      elem_q      <= E0;
      op_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      exp_q       <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= E0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= E0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      rd_vld_q    <= rd_vld_d;
      exp_q       <= exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign busy_o      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

  // Memory port is a pure decode of registered state; idle outputs read as zero.
  assign mem.req   = run;
  assign mem.we    = run & ~cur_rd;
  assign mem.addr  = run ? addr : '0;
  assign mem.wdata = {DataWidth{run & cur_dat}};
  assign mem.be    = '1;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench: two DUTs (N=16 with fault injection, N=12), behavioural latency-1 SRAMs.
// Latency: checks completion cycle, fail fields and the full request stream against a queue model.
// Backpressure: none.
module tb_sram_march_bist;
  import sram_bist_pkg::*;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_i, start_i, sel;
  int   fault;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt;
  int   cyc;
  logic mon_en = 1'b0;
  req_t q[$];
  req_t mon_e;

  always #5 clk = ~clk;

  sram_march_bist_if #(.AddrWidth(4), .DataWidth(8), .BeWidth(1)) m16 ();
  sram_march_bist_if #(.AddrWidth(4), .DataWidth(8), .BeWidth(1)) m12 ();

  logic       busy16, done16, pass16, busy12, done12, pass12;
  logic [3:0] fa16, fa12;
  logic [2:0] fe16, fe12;

  sram_march_bist #(.NumWords(16), .DataWidth(8), .ByteWidth(8), .Latency(1)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i & ~sel), .busy_o(busy16), .done_o(done16),
    .pass_o(pass16), .fail_addr_o(fa16), .fail_elem_o(fe16), .mem(m16));

  sram_march_bist #(.NumWords(12), .DataWidth(8), .ByteWidth(8), .Latency(1)) dut12 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i & sel), .busy_o(busy12), .done_o(done12),
    .pass_o(pass12), .fail_addr_o(fa12), .fail_elem_o(fe12), .mem(m12));

  // Behavioural SRAMs; the 16-word one can carry a stuck-at-1 or a no-1-to-0 cell.
  logic [7:0] mem16 [16];
  logic [7:0] mem12 [12];
  always @(posedge clk) begin
    if (m16.req) begin
      if (m16.we) begin
        if (fault == 1 && m16.addr == 4'd5)      mem16[m16.addr] <= m16.wdata | 8'h08;
        else if (fault == 2 && m16.addr == 4'd9) mem16[m16.addr] <= mem16[m16.addr] | m16.wdata;
        else                                     mem16[m16.addr] <= m16.wdata;
      end else begin
        m16.rdata <= mem16[m16.addr];
      end
    end
    if (m12.req) begin
      if (m12.we) mem12[m12.addr] <= m12.wdata;
      else        m12.rdata <= mem12[m12.addr];
    end
  end

  wire       c_busy  = sel ? busy12 : busy16;
  wire       c_done  = sel ? done12 : done16;
  wire       c_pass  = sel ? pass12 : pass16;
  wire [3:0] c_fa    = sel ? fa12 : fa16;
  wire [2:0] c_fe    = sel ? fe12 : fe16;
  wire       c_req   = sel ? m12.req : m16.req;
  wire       c_we    = sel ? m12.we : m16.we;
  wire [3:0] c_addr  = sel ? m12.addr : m16.addr;
  wire [7:0] c_wdata = sel ? m12.wdata : m16.wdata;
  wire       c_be    = sel ? m12.be[0] : m16.be[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference March C- request stream for an N-word array.
  task automatic push_march(input int n);
    for (int a = 0; a < n; a++) q.push_back('{1'b1, 4'(a), 8'h00});
    for (int a = 0; a < n; a++) begin q.push_back('{1'b0, 4'(a), 8'h00}); q.push_back('{1'b1, 4'(a), 8'hFF}); end
    for (int a = 0; a < n; a++) begin q.push_back('{1'b0, 4'(a), 8'h00}); q.push_back('{1'b1, 4'(a), 8'h00}); end
    for (int a = n - 1; a >= 0; a--) begin q.push_back('{1'b0, 4'(a), 8'h00}); q.push_back('{1'b1, 4'(a), 8'hFF}); end
    for (int a = n - 1; a >= 0; a--) begin q.push_back('{1'b0, 4'(a), 8'h00}); q.push_back('{1'b1, 4'(a), 8'h00}); end
    for (int a = 0; a < n; a++) q.push_back('{1'b0, 4'(a), 8'h00});
  endtask

  // Each request the DUT issues is popped and compared against the model stream.
  always @(negedge clk) begin
    if (mon_en && c_req) begin
      req_cnt++;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("req_stream", 32'({c_we, c_addr, (c_we ? c_wdata : 8'h00), c_be}),
              32'({mon_e.we, mon_e.addr, (mon_e.we ? mon_e.data : 8'h00), 1'b1}));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_status"}, 32'({c_busy, c_done, c_pass}), 32'd0);
    check({tag, "_fail"}, 32'({c_fa, c_fe}), 32'd0);
    check({tag, "_mem"}, 32'({c_req, c_we, c_addr, c_wdata, c_be}), 32'd1);
  endtask

  // Pulse start, wait for done (bounded) and check timing, result and request count.
  task automatic do_run(input logic s, input int n, input int done_cyc, input logic exp_pass,
                        input int exp_addr, input int exp_elem, input int exp_reqs, input string tag);
    sel = s;
    q.delete();
    push_march(n);
    req_cnt = 0;
    mon_en  = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    check({tag, "_cleared"}, 32'({c_busy, c_pass, c_fa, c_fe}), 32'({1'b1, 1'b0, 4'd0, 3'd0}));
    while (!c_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(done_cyc));
    check({tag, "_pass"}, 32'(c_pass), 32'(exp_pass));
    check({tag, "_fail_addr"}, 32'(c_fa), 32'(exp_addr));
    check({tag, "_fail_elem"}, 32'(c_fe), 32'(exp_elem));
    check({tag, "_req_count"}, 32'(req_cnt), 32'(exp_reqs));
    mon_en = 1'b0;
    q.delete();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; sel = 1'b0; fault = 0;
    repeat (2) @(negedge clk);
    check_reset("rst16");
    sel = 1'b1;
    check_reset("rst12");
    rst_i = 1'b0;
    @(negedge clk);

    do_run(1'b0, 16, 162, 1'b1, 0, 0, 160, "clean16");

    fault = 1;
    do_run(1'b0, 16, 29, 1'b0, 5, 1, 28, "stuck5");

    fault = 2;
    do_run(1'b0, 16, 95, 1'b0, 9, 3, 94, "no1to0_9");

    // Reset in the middle of a run, then a full rerun.
    fault = 0;
    sel = 1'b0;
    q.delete(); push_march(16); req_cnt = 0; mon_en = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 40) begin @(negedge clk); cyc++; end
    rst_i = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst_i = 1'b0; mon_en = 1'b0; q.delete();
    do_run(1'b0, 16, 162, 1'b1, 0, 0, 160, "rerun16");

    // start_i held high: no restart while busy, restart from DONE.
    sel = 1'b0;
    q.delete(); push_march(16); req_cnt = 0; mon_en = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!c_done && cyc < 400) begin @(negedge clk); cyc++; end
    check("hold_done_cycle", 32'(cyc), 32'd162);
    check("hold_pass", 32'(c_pass), 32'd1);
    check("hold_req_count", 32'(req_cnt), 32'd160);
    q.delete(); push_march(16); req_cnt = 0;
    @(negedge clk);
    check("hold_restart", 32'({c_done, c_busy}), 32'b01);
    start_i = 1'b0;
    cyc = 1;
    while (!c_done && cyc < 400) begin @(negedge clk); cyc++; end
    check("hold_rerun_cycle", 32'(cyc), 32'd162);
    check("hold_rerun_pass", 32'(c_pass), 32'd1);
    check("hold_rerun_reqs", 32'(req_cnt), 32'd160);
    mon_en = 1'b0; q.delete();

    do_run(1'b1, 12, 122, 1'b1, 0, 0, 120, "clean12");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
